// File: rtl/inst_rom_ctrl.sv
// Instruction-fetch front end: a single-entry line buffer in front of a handshaked
// backing memory, with registered read data, stall request and one-cycle error pulses.
module inst_rom_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_en,
    input  logic [SEL_W-1:0]  rom_write_en,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_write_data,
    output logic [DATA_W-1:0] rom_read_data,
    output logic              stall_req,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              addr_err,
    output logic              wr_err,
    output logic              bus_err
);
    // Handshake: mem_req/mem_addr are held stable from request until mem_ack is
    // sampled high or the wait counter expires; mem_ack outside FETCH is ignored.
    typedef enum logic {IDLE, FETCH} state_t;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                stall_q, stall_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                flushed_q, flushed_d;
    logic                addr_err_q, addr_err_d;
    logic                wr_err_q, wr_err_d;
    logic                bus_err_q, bus_err_d;

    logic unused_wdata;
    assign unused_wdata = ^rom_write_data;

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        stall_d     = stall_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        cnt_d       = cnt_q;
        flushed_d   = flushed_q;
        addr_err_d  = 1'b0;
        wr_err_d    = 1'b0;
        bus_err_d   = 1'b0;

        if (flush) begin
            buf_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (rom_en) begin
                    if (|rom_write_en) begin
                        wr_err_d = 1'b1;
                    end else if (|rom_addr[1:0]) begin
                        addr_err_d = 1'b1;
                        rd_d       = '0;
                    end else if (buf_valid_q && !flush && (rom_addr == buf_addr_q)) begin
                        rd_d = buf_data_q;
                    end else begin
                        state_d    = FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = rom_addr;
                        stall_d    = 1'b1;
                        cnt_d      = '0;
                        flushed_d  = 1'b0;
                    end
                end
            end
            FETCH: begin
                // A flush seen at any point of the fetch keeps its data out of the buffer.
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (mem_ack) begin
                    rd_d      = mem_rdata;
                    mem_req_d = 1'b0;
                    stall_d   = 1'b0;
                    state_d   = IDLE;
                    if (!flushed_q && !flush) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = mem_addr_q;
                        buf_data_d  = mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    rd_d      = '0;
                    mem_req_d = 1'b0;
                    stall_d   = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            stall_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            cnt_q       <= '0;
            flushed_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            wr_err_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            stall_q     <= stall_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            cnt_q       <= cnt_d;
            flushed_q   <= flushed_d;
            addr_err_q  <= addr_err_d;
            wr_err_q    <= wr_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign rom_read_data = rd_q;
    assign stall_req     = stall_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign addr_err      = addr_err_q;
    assign wr_err        = wr_err_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Bench for inst_rom_ctrl: directed scenarios plus randomized fetches checked
// against a transaction-level model of the line buffer and read-data register.
module tb_inst_rom_ctrl;
    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        rom_en;
    logic [3:0]  rom_write_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_write_data;
    logic [31:0] rom_read_data;
    logic        stall_req;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        addr_err;
    logic        wr_err;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_rd;
    bit          m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    inst_rom_ctrl #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rom_en(rom_en), .rom_write_en(rom_write_en),
        .rom_addr(rom_addr), .rom_write_data(rom_write_data),
        .rom_read_data(rom_read_data), .stall_req(stall_req), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .addr_err(addr_err), .wr_err(wr_err),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input bit noise_ack);
        rom_en    = 1'b0;
        mem_ack   = noise_ack;
        mem_rdata = $urandom;
        rom_addr  = $urandom;
        tick();
        mem_ack = 1'b0;
        chk("idle_rd", rom_read_data, m_rd);
        chk("idle_mem_req", {31'd0, mem_req}, 0);
        chk("idle_stall", {31'd0, stall_req}, 0);
        chk("idle_errs", {29'd0, addr_err, wr_err, bus_err}, 0);
    endtask

    // One request: delay >= TO means the memory never answers.
    task automatic do_req(input logic [31:0] addr, input logic [3:0] we, input bit fl,
                          input int delay, input int flush_at, input logic [31:0] data);
        bit fl_seen;
        int last;
        fl_seen        = 0;
        last           = (delay < TO) ? delay : TO - 1;
        rom_en         = 1'b1;
        rom_addr       = addr;
        rom_write_en   = we;
        flush          = fl;
        rom_write_data = $urandom;
        tick();
        rom_en       = 1'b0;
        flush        = 1'b0;
        rom_write_en = 4'd0;
        rom_addr     = $urandom;
        if (fl) m_valid = 0;
        if (we != 4'd0) begin
            chk("wr_err", {31'd0, wr_err}, 1);
            chk("wr_no_addr_err", {31'd0, addr_err}, 0);
            chk("wr_no_mem_req", {31'd0, mem_req}, 0);
            chk("wr_rd_hold", rom_read_data, m_rd);
        end else if (addr[1:0] != 2'd0) begin
            m_rd = 32'd0;
            chk("addr_err", {31'd0, addr_err}, 1);
            chk("addr_no_wr_err", {31'd0, wr_err}, 0);
            chk("addr_no_mem_req", {31'd0, mem_req}, 0);
            chk("addr_rd_zero", rom_read_data, 0);
        end else if (m_valid && addr == m_addr) begin
            m_rd = m_data;
            chk("hit_rd", rom_read_data, m_data);
            chk("hit_stall", {31'd0, stall_req}, 0);
            chk("hit_mem_req", {31'd0, mem_req}, 0);
        end else begin
            chk("miss_mem_req", {31'd0, mem_req}, 1);
            chk("miss_mem_addr", mem_addr, addr);
            chk("miss_stall", {31'd0, stall_req}, 1);
            for (int c = 0; c <= last; c++) begin
                mem_ack   = (c == delay);
                mem_rdata = (c == delay) ? data : $urandom;
                flush     = (c == flush_at);
                if (c == flush_at) begin
                    fl_seen = 1;
                    m_valid = 0;
                end
                tick();
                mem_ack = 1'b0;
                flush   = 1'b0;
                if (c < last) begin
                    chk("fetch_mem_req", {31'd0, mem_req}, 1);
                    chk("fetch_mem_addr", mem_addr, addr);
                    chk("fetch_stall", {31'd0, stall_req}, 1);
                    chk("fetch_bus_err", {31'd0, bus_err}, 0);
                end
            end
            if (delay < TO) begin
                m_rd = data;
                if (!fl_seen) begin
                    m_valid = 1;
                    m_addr  = addr;
                    m_data  = data;
                end
                chk("ack_rd", rom_read_data, data);
                chk("ack_no_bus_err", {31'd0, bus_err}, 0);
            end else begin
                m_rd = 32'd0;
                chk("timeout_bus_err", {31'd0, bus_err}, 1);
                chk("timeout_rd", rom_read_data, 0);
            end
            chk("done_mem_req", {31'd0, mem_req}, 0);
            chk("done_stall", {31'd0, stall_req}, 0);
        end
    endtask

    initial begin
        logic [31:0] pool [4];
        logic [31:0] a;
        pool[0] = 32'h0000_0100;
        pool[1] = 32'h0000_0104;
        pool[2] = 32'hBFC0_0000;
        pool[3] = 32'h0000_0200;

        rst = 1'b0; rom_en = 1'b0; rom_write_en = 4'd0; rom_addr = 32'd0;
        rom_write_data = 32'd0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        m_rd = 32'd0; m_valid = 0; m_addr = 32'd0; m_data = 32'd0;
        tick();
        tick();
        chk("rst_rd", rom_read_data, 0);
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stall", {31'd0, stall_req}, 0);
        chk("rst_errs", {29'd0, addr_err, wr_err, bus_err}, 0);
        rst = 1'b1;
        idle_cycle(1);

        // Miss then hit
        do_req(32'hBFC0_0000, 4'd0, 0, 3, -1, 32'h3C1D_0001);
        idle_cycle(0);
        do_req(32'hBFC0_0000, 4'd0, 0, 0, -1, 32'd0);
        idle_cycle(1);
        // Timeout, buffer survives
        do_req(32'h0000_0200, 4'd0, 0, 100, -1, 32'd0);
        idle_cycle(0);
        do_req(32'hBFC0_0000, 4'd0, 0, 0, -1, 32'd0);
        idle_cycle(0);
        // Error pulses
        do_req(32'hBFC0_0002, 4'd0, 0, 0, -1, 32'd0);
        idle_cycle(0);
        do_req(32'hBFC0_0000, 4'hF, 0, 0, -1, 32'd0);
        idle_cycle(0);
        // Flush cases
        do_req(32'h0000_0100, 4'd0, 0, 2, -1, 32'hAAAA_0100);
        idle_cycle(0);
        do_req(32'h0000_0100, 4'd0, 1, 1, -1, 32'hBBBB_0100);
        idle_cycle(0);
        do_req(32'h0000_0104, 4'd0, 0, 2, 1, 32'hCCCC_0104);
        idle_cycle(0);
        do_req(32'h0000_0104, 4'd0, 0, 0, -1, 32'hDDDD_0104);
        idle_cycle(0);
        // Ack on the last allowed cycle wins over timeout
        do_req(32'h0000_0300, 4'd0, 0, TO - 1, -1, 32'h1234_5678);
        idle_cycle(0);

        // Reset during the second FETCH cycle
        rom_en = 1'b1; rom_addr = 32'h0000_0400;
        tick();
        rom_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_rd = 32'd0; m_valid = 0;
        chk("rstf_mem_req", {31'd0, mem_req}, 0);
        chk("rstf_stall", {31'd0, stall_req}, 0);
        chk("rstf_rd", rom_read_data, 0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("rstf_late_ack_rd", rom_read_data, 0);
        chk("rstf_late_ack_req", {31'd0, mem_req}, 0);
        chk("rstf_late_ack_errs", {29'd0, addr_err, wr_err, bus_err}, 0);
        idle_cycle(0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            a = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_req(a,
                   ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                   ($urandom_range(0, 7) == 0),
                   $urandom_range(0, TO + 1),
                   ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1,
                   $urandom);
            for (int g = 0; g < $urandom_range(1, 3); g++) idle_cycle($urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
